// File: rtl/dataout_sink.sv
// Ejection-side flit collector for one NoC node: stores flits, keeps delivery stats, registered readback.
// Optional per-source sequence checking enabled by DATAOUT_SINK_SEQ_CHECK_EN (adds seq_err_count).
module dataout_sink #(
  parameter logic [3:0] NODE_ID = 4'd3,
  parameter int         DEPTH   = 30,
  parameter int         ADDR_W  = 5,
  parameter int         CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [19:0]       datain,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [19:0]       rd_data,
  output logic [CNT_W-1:0]  flit_count,
  output logic [CNT_W-1:0]  misroute_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              full,
  output logic              done
`ifdef DATAOUT_SINK_SEQ_CHECK_EN
  ,
  output logic [CNT_W-1:0]  seq_err_count
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  flit_count_q, flit_count_d;
  logic [CNT_W-1:0]  misroute_count_q, misroute_count_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic [19:0]       rd_data_q, rd_data_d;
  logic [19:0]       mem_q [DEPTH];

  logic flit_vld;
  logic store;
  logic last_slot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // A null flit is indistinguishable from an idle cycle.
  assign flit_vld  = in_valid && (datain != 20'h00000);
  assign store     = flit_vld && (state_q != DONE);
  assign last_slot = (wr_ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    flit_count_d     = flit_count_q;
    misroute_count_d = misroute_count_q;
    drop_count_d     = drop_count_q;
    full_d           = full_q;
    done_d           = done_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (store) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          flit_count_d = sat_inc(flit_count_q);
          if (datain[19:16] != NODE_ID) misroute_count_d = sat_inc(misroute_count_q);
          if (last_slot) full_d = 1'b1;
          if (datain[10] || last_slot) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      DONE: begin
        if (flit_vld) drop_count_d = sat_inc(drop_count_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // Slots at or above flit_count read as zero, so a same-cycle write is never visible early.
  always_comb begin
    rd_data_d = 20'h00000;
    if (CNT_W'(rd_addr) < flit_count_q) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      flit_count_q     <= '0;
      misroute_count_q <= '0;
      drop_count_q     <= '0;
      full_q           <= 1'b0;
      done_q           <= 1'b0;
      rd_data_q        <= 20'h00000;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      flit_count_q     <= flit_count_d;
      misroute_count_q <= misroute_count_d;
      drop_count_q     <= drop_count_d;
      full_q           <= full_d;
      done_q           <= done_d;
      rd_data_q        <= rd_data_d;
    end
  end

  // Capture buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= datain;
  end

  assign rd_data        = rd_data_q;
  assign flit_count     = flit_count_q;
  assign misroute_count = misroute_count_q;
  assign drop_count     = drop_count_q;
  assign full           = full_q;
  assign done           = done_q;

`ifdef DATAOUT_SINK_SEQ_CHECK_EN
  logic [3:0]       exp_q [16];
  logic [3:0]       exp_d [16];
  logic [CNT_W-1:0] seq_err_count_q, seq_err_count_d;

  // Expected seq resyncs to whatever arrived, so one gap costs exactly one error.
  always_comb begin
    exp_d           = exp_q;
    seq_err_count_d = seq_err_count_q;
    if (store) begin
      if (datain[7:4] != exp_q[datain[15:12]]) seq_err_count_d = sat_inc(seq_err_count_q);
      exp_d[datain[15:12]] = datain[7:4] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) exp_q[i] <= 4'd1;
      seq_err_count_q <= '0;
    end else begin
      exp_q           <= exp_d;
      seq_err_count_q <= seq_err_count_d;
    end
  end

  assign seq_err_count = seq_err_count_q;
`endif

endmodule

// File: tb/tb_dataout_sink.sv
// Directed bench for dataout_sink: hand-computed expectations checked with immediate assertions.
module tb_dataout_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] datain = 20'h00000;
  logic [4:0]  rd_addr = 5'd0;
  logic [19:0] rd_data;
  logic [7:0]  flit_count, misroute_count, drop_count;
  logic        full, done;
`ifdef DATAOUT_SINK_SEQ_CHECK_EN
  logic [7:0]  seq_err_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dataout_sink #(.NODE_ID(4'd3), .DEPTH(30), .ADDR_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .datain(datain), .rd_addr(rd_addr),
    .rd_data(rd_data), .flit_count(flit_count), .misroute_count(misroute_count),
    .drop_count(drop_count), .full(full), .done(done)
`ifdef DATAOUT_SINK_SEQ_CHECK_EN
    , .seq_err_count(seq_err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one flit for one cycle; returns #1 after the sampling edge.
  task automatic send(input logic [19:0] f);
    @(negedge clk);
    in_valid = 1'b1;
    datain   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    datain   = 20'h00000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic readback(input logic [4:0] a, input logic [19:0] exp, input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    rd_addr  = a;
    @(posedge clk);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"},  32'(flit_count), 32'd0);
    check({tag, "_mis"},  32'(misroute_count), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd"},   32'(rd_data), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    datain = 20'h00000;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    do_reset();

    // Test 1: normal stream ending with a tail flit
    send(20'h00000);
    send(20'h30010);
    send(20'h30020);
    send(20'h31011);
    send(20'h31021);
    send(20'h32012);
    send(20'h32022);
    check("t1_cnt6", 32'(flit_count), 32'd6);
    check("t1_done_pre", 32'(done), 32'd0);
    send(20'h33423);
    check("t1_cnt7", 32'(flit_count), 32'd7);
    check("t1_done", 32'(done), 32'd1);
    for (int i = 0; i < 22; i++) send(20'h00000);
    check("t1_full", 32'(full), 32'd0);
    check("t1_mis", 32'(misroute_count), 32'd0);
    check("t1_drop", 32'(drop_count), 32'd0);
    check("t1_cnt_after", 32'(flit_count), 32'd7);
    readback(5'd6, 20'h33423, "t1_rd6");
    readback(5'd7, 20'h00000, "t1_rd7");
    readback(5'd0, 20'h30010, "t1_rd0");

    // Test 2: misrouted flit is still stored
    do_reset();
    send(20'h20010);
    check("t2_mis_first", 32'(misroute_count), 32'd1);
    send(20'h30010);
    send(20'h33423);
    check("t2_mis", 32'(misroute_count), 32'd1);
    check("t2_cnt", 32'(flit_count), 32'd3);
    readback(5'd0, 20'h20010, "t2_rd0");

    // Test 3: overflow, full on the 30th flit, rest dropped
    do_reset();
    for (int i = 1; i <= 29; i++) send(20'h30010);
    check("t3_full_29", 32'(full), 32'd0);
    check("t3_done_29", 32'(done), 32'd0);
    readback(5'd28, 20'h30010, "t3_rd28");
    readback(5'd29, 20'h00000, "t3_rd29_pre");
    send(20'h30010);
    check("t3_full_30", 32'(full), 32'd1);
    check("t3_done_30", 32'(done), 32'd1);
    check("t3_drop_30", 32'(drop_count), 32'd0);
    send(20'h30010);
    send(20'h30010);
    send(20'h33423);
    check("t3_drop", 32'(drop_count), 32'd3);
    check("t3_cnt", 32'(flit_count), 32'd30);
    check("t3_mis", 32'(misroute_count), 32'd0);
    readback(5'd29, 20'h30010, "t3_rd29");
    readback(5'd31, 20'h00000, "t3_rd31");

    // Test 4: reset mid-stream discards state
    do_reset();
    send(20'h30010);
    send(20'h20010);
    send(20'h30030);
    send(20'h30040);
    send(20'h30050);
    check("t4_cnt5", 32'(flit_count), 32'd5);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    datain = 20'h30060;
    #1;
    check_all_zero("t4_inrst");
    @(posedge clk);
    #1;
    check("t4_inrst_cnt", 32'(flit_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    send(20'h30020);
    send(20'h33423);
    check("t4_cnt", 32'(flit_count), 32'd2);
    check("t4_done", 32'(done), 32'd1);
    readback(5'd0, 20'h30020, "t4_rd0");

    // Test 5: sustained null flits change nothing
    do_reset();
    for (int i = 0; i < 50; i++) send(20'h00000);
    check_all_zero("t5_null");
    send(20'h30010);
    check("t5_cnt1", 32'(flit_count), 32'd1);
    check("t5_done", 32'(done), 32'd0);

`ifdef DATAOUT_SINK_SEQ_CHECK_EN
    // Test 6: sequence checking with resync
    do_reset();
    check("t6_seq_rst", 32'(seq_err_count), 32'd0);
    send(20'h30010);
    check("t6_seq_a", 32'(seq_err_count), 32'd0);
    send(20'h30030);
    check("t6_seq_b", 32'(seq_err_count), 32'd1);
    send(20'h30040);
    check("t6_seq_c", 32'(seq_err_count), 32'd1);
    send(20'h31021);
    check("t6_seq", 32'(seq_err_count), 32'd2);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
